// File: rtl/neuron_accumulator.sv
// Sequential dot-product accumulator for one neuron.
// Takes a bias and then LEN sign-magnitude terms over a valid/ready stream.
// Overflow is sticky for the neuron. The finished sum goes through ReLU and
// is presented with a one-cycle done pulse.
module neuron_accumulator #(
    parameter int LEN   = 784,
    parameter int CNT_W = 10
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iStart,
    input  logic [30:0] iBias,
    input  logic        iValid,
    input  logic [30:0] iTerm,
    output logic        oReady,
    output logic        oBusy,
    output logic        oDone,
    output logic [30:0] oResult,
    output logic        oOverflow
);

    // Negative sign with zero magnitude marks an overflowed sum, never a value.
    localparam logic [30:0]      TOKEN = 31'h4000_0000;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FINISH
    } state_e;

    state_e           state_q;
    logic [30:0]      acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [30:0]      result_q;
    logic             overflow_q;

    // Next accumulator value and overflow for acc + term.
    logic [30:0] add_d;
    logic        add_ovf_d;
    logic [30:0] mag_sum;
    logic [29:0] acc_mag;
    logic [29:0] term_mag;

    // Sign-magnitude adder: token propagation, zero shortcut, same-sign add, cancel.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        add_d     = acc_q;
        add_ovf_d = 1'b0;
        acc_mag   = acc_q[29:0];
        term_mag  = iTerm[29:0];
        mag_sum   = {1'b0, acc_mag} + {1'b0, term_mag};

        if (acc_q == TOKEN || iTerm == TOKEN) begin
            add_d     = TOKEN;
            add_ovf_d = 1'b1;
        end else if (acc_q == '0) begin
            add_d = iTerm;
        end else if (iTerm == '0) begin
            add_d = acc_q;
        end else if (acc_q[30] == iTerm[30]) begin
            if (mag_sum[30]) begin
                add_d     = TOKEN;
                add_ovf_d = 1'b1;
            end else begin
                add_d = {acc_q[30], mag_sum[29:0]};
            end
        end else if (acc_mag == term_mag) begin
            add_d = '0;
        end else if (acc_mag > term_mag) begin
            add_d = {acc_q[30], acc_mag - term_mag};
        end else begin
            add_d = {iTerm[30], term_mag - acc_mag};
        end
    end

    // Control FSM with the accumulator datapath and registered outputs.
    always_ff @(posedge iClk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (iRst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (iStart) begin
                        acc_q   <= iBias;
                        cnt_q   <= '0;
                        ovf_q   <= (iBias == TOKEN);
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (iValid && ready_q) begin
                        // Once overflowed, the token is held and the remaining terms are only counted.
                        if (!ovf_q) begin
                            acc_q <= add_d;
                            ovf_q <= add_ovf_d;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            ready_q <= 1'b0;
                            state_q <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    // ReLU clamps negatives to +0. The token bypasses the clamp.
                    result_q   <= ovf_q ? TOKEN : (acc_q[30] ? 31'h0 : acc_q);
                    overflow_q <= ovf_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oReady    = ready_q;
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oResult   = result_q;
    assign oOverflow = overflow_q;

endmodule
